// File: rtl/mem_port1_arbiter_if.sv
// rtl/mem_port1_arbiter_if.sv - requester and memory port1 signals of the port1 arbiter
// slave = arbiter side, master = requesters plus memory side.
interface mem_port1_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              r0_req_valid;
  logic              r0_req_ready;
  logic [ADDR_W-1:0] r0_req_addr;
  logic              r0_req_wen;
  logic [STRB_W-1:0] r0_req_wstrb;
  logic [DATA_W-1:0] r0_req_wdata;
  logic              r0_resp_valid;
  logic              r0_resp_ready;
  logic [DATA_W-1:0] r0_resp_rdata;
  logic              r0_resp_err;

  logic              r1_req_valid;
  logic              r1_req_ready;
  logic [ADDR_W-1:0] r1_req_addr;
  logic              r1_req_wen;
  logic [STRB_W-1:0] r1_req_wstrb;
  logic [DATA_W-1:0] r1_req_wdata;
  logic              r1_resp_valid;
  logic              r1_resp_ready;
  logic [DATA_W-1:0] r1_resp_rdata;
  logic              r1_resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req_valid, r0_req_addr, r0_req_wen, r0_req_wstrb, r0_req_wdata, r0_resp_ready,
    output r0_req_ready, r0_resp_valid, r0_resp_rdata, r0_resp_err,
    input  r1_req_valid, r1_req_addr, r1_req_wen, r1_req_wstrb, r1_req_wdata, r1_resp_ready,
    output r1_req_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
    output mem_addr, mem_ren, mem_wen, mem_wstrb, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output r0_req_valid, r0_req_addr, r0_req_wen, r0_req_wstrb, r0_req_wdata, r0_resp_ready,
    input  r0_req_ready, r0_resp_valid, r0_resp_rdata, r0_resp_err,
    output r1_req_valid, r1_req_addr, r1_req_wen, r1_req_wstrb, r1_req_wdata, r1_resp_ready,
    input  r1_req_ready, r1_resp_valid, r1_resp_rdata, r1_resp_err,
    input  mem_addr, mem_ren, mem_wen, mem_wstrb, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port1_arbiter.sv
// rtl/mem_port1_arbiter.sv - shares memory port1 between the LSU (r0) and the debug loader (r1)
// One registered access per grant: IDLE (accept) -> ACCESS (memory cycle) -> RESP (handshake).
module mem_port1_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port1_arbiter_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic grant_any;
  logic grant_r1;
  logic winner_resp_ready;
  logic in_idle, in_access, in_resp;

  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // r1 wins when alone, or on a tie when round-robin says r0 went last.
  assign grant_any = bus.r0_req_valid | bus.r1_req_valid;
  assign grant_r1  = bus.r1_req_valid & (~bus.r0_req_valid | (~FIXED_PRIO & ~last_grant_q));
  assign winner_resp_ready = winner_q ? bus.r1_resp_ready : bus.r0_resp_ready;

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          winner_d     = grant_r1;
          last_grant_d = grant_r1;
          addr_d       = grant_r1 ? bus.r1_req_addr  : bus.r0_req_addr;
          wen_d        = grant_r1 ? bus.r1_req_wen   : bus.r0_req_wen;
          wstrb_d      = grant_r1 ? bus.r1_req_wstrb : bus.r0_req_wstrb;
          wdata_d      = grant_r1 ? bus.r1_req_wdata : bus.r0_req_wdata;
          err_d        = grant_r1 ? (bus.r1_req_addr[1:0] != 2'b00)
                                  : (bus.r0_req_addr[1:0] != 2'b00);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (!wen_q && !err_q) ? bus.mem_rdata : '0;
        state_d = RESP;
      end
      RESP: begin
        if (winner_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.r0_req_ready  = in_idle & bus.r0_req_valid & ~grant_r1;
  assign bus.r1_req_ready  = in_idle & grant_r1;

  assign bus.r0_resp_valid = in_resp & ~winner_q;
  assign bus.r0_resp_rdata = (in_resp & ~winner_q) ? rdata_q : '0;
  assign bus.r0_resp_err   = in_resp & ~winner_q & err_q;
  assign bus.r1_resp_valid = in_resp & winner_q;
  assign bus.r1_resp_rdata = (in_resp & winner_q) ? rdata_q : '0;
  assign bus.r1_resp_err   = in_resp & winner_q & err_q;

  // Misaligned accesses still present the address but never enable the memory.
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wstrb = in_access ? wstrb_q : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;
  assign bus.mem_ren   = in_access & ~err_q & ~wen_q;
  assign bus.mem_wen   = in_access & ~err_q & wen_q;
endmodule

// File: tb/tb_mem_port1_arbiter.sv
// tb/tb_mem_port1_arbiter.sv - directed scoreboard bench for mem_port1_arbiter
module tb_mem_port1_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  mem_port1_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi ();
  mem_port1_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bf ();

  mem_port1_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .bus(bi)
  );
  mem_port1_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bf)
  );

  logic [31:0] mem [64];
  assign bi.mem_rdata = mem[bi.mem_addr[7:2]];
  assign bf.mem_rdata = {bf.mem_addr[15:0], 16'hA5A5};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (bi.mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (bi.mem_wstrb[b]) mem[bi.mem_addr[7:2]][8*b +: 8] <= bi.mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [31:0] a, input bit w,
                           input logic [3:0] s, input logic [31:0] d);
    if (id) begin
      bi.r1_req_valid = v; bi.r1_req_addr = a; bi.r1_req_wen = w;
      bi.r1_req_wstrb = s; bi.r1_req_wdata = d;
    end else begin
      bi.r0_req_valid = v; bi.r0_req_addr = a; bi.r0_req_wen = w;
      bi.r0_req_wstrb = s; bi.r0_req_wdata = d;
    end
  endtask

  task automatic push_exp(input bit id, input logic [31:0] a, input bit w,
                          input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    e.id    = id;
    e.err   = (a[1:0] != 2'b00);
    e.rdata = (!w && !e.err) ? ref_mem[a[7:2]] : 32'h0;
    if (w && !e.err)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
    sb.push_back(e);
  endtask

  task automatic resp_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_resp_valid"}, e.id ? bi.r1_resp_valid : bi.r0_resp_valid, 1);
    chk({tag, "_other_resp_valid"}, e.id ? bi.r0_resp_valid : bi.r1_resp_valid, 0);
    chk({tag, "_resp_rdata"}, e.id ? bi.r1_resp_rdata : bi.r0_resp_rdata, e.rdata);
    chk({tag, "_resp_err"}, e.id ? bi.r1_resp_err : bi.r0_resp_err, e.err);
  endtask

  task automatic do_txn(input string tag, input bit id, input logic [31:0] a, input bit w,
                        input logic [3:0] s, input logic [31:0] d);
    bit e;
    e = (a[1:0] != 2'b00);
    tick();
    drive_req(id, 1'b1, a, w, s, d);
    #1;
    chk({tag, "_req_ready"}, id ? bi.r1_req_ready : bi.r0_req_ready, 1);
    chk({tag, "_other_req_ready"}, id ? bi.r0_req_ready : bi.r1_req_ready, 0);
    push_exp(id, a, w, s, d);
    tick();
    drive_req(id, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk({tag, "_mem_addr"}, bi.mem_addr, a);
    chk({tag, "_mem_ren"}, bi.mem_ren, !w && !e);
    chk({tag, "_mem_wen"}, bi.mem_wen, w && !e);
    if (w && !e) begin
      chk({tag, "_mem_wdata"}, bi.mem_wdata, d);
      chk({tag, "_mem_wstrb"}, bi.mem_wstrb, s);
    end
    tick();
    resp_check(tag);
    if (id) bi.r1_resp_ready = 1'b1; else bi.r0_resp_ready = 1'b1;
    tick();
    bi.r0_resp_ready = 1'b0;
    bi.r1_resp_ready = 1'b0;
    #1;
    chk({tag, "_back_idle"}, bi.r0_resp_valid | bi.r1_resp_valid, 0);
  endtask

  initial begin
    bit last_m;
    bit exp_w;

    rst = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    drive_req(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    bi.r0_resp_ready = 1'b0; bi.r1_resp_ready = 1'b0;
    bf.r0_req_valid = 1'b0; bf.r0_req_addr = 32'h0; bf.r0_req_wen = 1'b0;
    bf.r0_req_wstrb = 4'h0; bf.r0_req_wdata = 32'h0; bf.r0_resp_ready = 1'b0;
    bf.r1_req_valid = 1'b0; bf.r1_req_addr = 32'h0; bf.r1_req_wen = 1'b0;
    bf.r1_req_wstrb = 4'h0; bf.r1_req_wdata = 32'h0; bf.r1_resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {bi.r0_req_ready, bi.r1_req_ready}, 0);
    chk("rst_resp_valid", {bi.r0_resp_valid, bi.r1_resp_valid}, 0);
    chk("rst_mem_en", {bi.mem_ren, bi.mem_wen}, 0);
    chk("rst_mem_addr", bi.mem_addr, 0);
    rst = 1'b0;
    mem_clr = 1'b0;

    do_txn("wr_r0_10", 1'b0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    do_txn("rd_r1_10", 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    do_txn("wr_r1_20_part", 1'b1, 32'h20, 1'b1, 4'h3, 32'h11223344);
    do_txn("rd_r0_20", 1'b0, 32'h20, 1'b0, 4'h0, 32'h0);
    do_txn("rd_r0_13_err", 1'b0, 32'h13, 1'b0, 4'h0, 32'h0);
    do_txn("wr_r1_22_err", 1'b1, 32'h22, 1'b1, 4'hF, 32'hFFFFFFFF);
    do_txn("rd_r1_20_after_err", 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);

    // Response stall: r0 holds resp_ready low while r1 waits.
    tick();
    drive_req(1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    chk("hold_r0_req_ready", bi.r0_req_ready, 1);
    push_exp(1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
    #1;
    chk("hold_access_r1_ready", bi.r1_req_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", bi.r0_resp_valid, 1);
      chk("hold_resp_rdata", bi.r0_resp_rdata, sb[0].rdata);
      chk("hold_r1_req_ready", bi.r1_req_ready, 0);
      tick();
    end
    resp_check("hold_r0");
    bi.r0_resp_ready = 1'b1;
    tick();
    bi.r0_resp_ready = 1'b0;
    #1;
    chk("hold_r1_accept_after", bi.r1_req_ready, 1);
    push_exp(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
    tick();
    drive_req(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("hold_r1_mem_ren", bi.mem_ren, 1);
    chk("hold_r1_mem_addr", bi.mem_addr, 32'h20);
    tick();
    resp_check("hold_r1");
    bi.r1_resp_ready = 1'b1;
    tick();
    bi.r1_resp_ready = 1'b0;

    // Reset during the ACCESS cycle of a read aborts it.
    tick();
    drive_req(1'b1, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    chk("abort_r1_req_ready", bi.r1_req_ready, 1);
    tick();
    drive_req(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("abort_access_mem_ren", bi.mem_ren, 1);
    rst = 1'b1;
    tick();
    chk("abort_mem_outputs", {bi.mem_ren, bi.mem_wen, bi.mem_addr}, 0);
    chk("abort_resp_valid", {bi.r0_resp_valid, bi.r1_resp_valid}, 0);
    rst = 1'b0;
    tick();
    chk("abort_no_resp_later", {bi.r0_resp_valid, bi.r1_resp_valid}, 0);

    // Both valid continuously: round-robin starting from r0 after reset.
    drive_req(1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
    bi.r0_resp_ready = 1'b1;
    bi.r1_resp_ready = 1'b1;
    last_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_w = ~last_m;
      chk("rr_r0_req_ready", bi.r0_req_ready, !exp_w);
      chk("rr_r1_req_ready", bi.r1_req_ready, exp_w);
      last_m = exp_w;
      push_exp(exp_w, exp_w ? 32'h20 : 32'h10, 1'b0, 4'h0, 32'h0);
      tick();
      tick();
      resp_check("rr");
      tick();
    end
    drive_req(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_req(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    bi.r0_resp_ready = 1'b0;
    bi.r1_resp_ready = 1'b0;

    // Fixed priority instance: r0 wins every tie, r1 starves.
    bf.r0_req_valid = 1'b1; bf.r0_req_addr = 32'h40;
    bf.r1_req_valid = 1'b1; bf.r1_req_addr = 32'h80;
    bf.r0_resp_ready = 1'b1; bf.r1_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_r0_req_ready", bf.r0_req_ready, 1);
      chk("fp_r1_req_ready", bf.r1_req_ready, 0);
      tick();
      chk("fp_r1_ready_access", bf.r1_req_ready, 0);
      tick();
      chk("fp_r0_resp_valid", bf.r0_resp_valid, 1);
      chk("fp_r0_resp_rdata", bf.r0_resp_rdata, {16'h0040, 16'hA5A5});
      chk("fp_r1_resp_valid", bf.r1_resp_valid, 0);
      tick();
    end
    bf.r0_req_valid = 1'b0;
    bf.r1_req_valid = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port1_arbiter.md
Name: mem_port1_arbiter

Overview:
- Shares the single data port (port1) of the unified instruction/data memory between two requesters: r0 (CPU load/store unit) and r1 (debug/program loader).
- Sits between the requesters and the memory.
- Registers each winning request, sequences one memory access, registers the response and returns it with a valid/ready handshake.
- Port0 (instruction fetch) is not touched.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- FIXED_PRIO, 0. 0 = round-robin between r0 and r1; 1 = r0 always wins ties.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rN_req_valid  in  1  request valid, for N = 0, 1.
- rN_req_ready  out  1  request accepted this cycle.
- rN_req_addr  in  ADDR_W  byte address.
- rN_req_wen  in  1  1 = write, 0 = read.
- rN_req_wstrb  in  DATA_W/8  byte enables for writes.
- rN_req_wdata  in  DATA_W  write data.
- rN_resp_valid  out  1  response valid.
- rN_resp_ready  in  1  response consumed.
- rN_resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rN_resp_err  out  1  misaligned access flag.
- mem_addr  out  ADDR_W  to memory port1 address.
- mem_ren  out  1  to memory port1 read enable.
- mem_wen  out  1  to memory port1 write enable.
- mem_wstrb  out  DATA_W/8  to memory port1 byte strobes.
- mem_wdata  out  DATA_W  to memory port1 write data.
- mem_rdata  in  DATA_W  memory port1 read data; combinational from mem_addr.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- FSM states: IDLE, ACCESS, RESP.
- Registers held: winner id, latched request (addr, wen, wstrb, wdata), err bit, rdata register, last_grant bit.

Reset:
- state=IDLE, last_grant=1 (so r0 wins the first tie), rdata/err/latched regs=0.
- All ready/valid/mem_* outputs = 0.
- Reset asserted mid-transaction aborts it: no response is delivered. A write already in ACCESS at that edge is not guaranteed.

IDLE:
- If no req_valid, stay in IDLE.
- If exactly one req_valid, that requester wins.
- If both are valid: with FIXED_PRIO=1, r0 wins; otherwise the requester != last_grant wins.
- The winner's req_ready is asserted combinationally in this cycle; the loser's req_ready stays 0.
- On the clock edge: latch the winner's fields, set last_grant=winner, set err = (addr[1:0] != 0), go to ACCESS.
- req_ready is never asserted outside IDLE.

ACCESS (exactly 1 cycle):
- mem_addr/mem_wstrb/mem_wdata are driven from the latched regs.
- If !err: mem_wen = latched wen, mem_ren = !latched wen.
- If err: mem_ren = mem_wen = 0, so no memory side effect.
- At the edge: rdata_reg = (read && !err) ? mem_rdata : 0. Go to RESP.
- mem_* are 0 in every state other than ACCESS.

RESP:
- Winner's resp_valid=1; resp_rdata and resp_err are held stable. The other requester's resp_valid=0.
- Stay in RESP until the winner's resp_ready=1, then go to IDLE on that edge.
- resp_ready asserted in other states is ignored.

Timing:
- Latency: request accepted in cycle T, resp_valid is first high in cycle T+2.
- Minimum 3 cycles per transaction; the next acceptance can occur at T+3 at the earliest.

Other rules:
- A requester must hold its request fields stable while valid && !ready. Fields changing after acceptance have no effect.
- Round-robin fairness: with both requesters valid continuously, grants alternate r0, r1, r0, …
- A new request from the requester currently waiting for its response is simply not accepted until the FSM returns to IDLE.
- Outputs to both requesters are registered or decoded from state only. The exception is req_ready, which also depends on req_valid.

Test Plan:
- Reset, then r0 writes addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> r0_req_ready=1 at T; mem_wen=1 with mem_addr=0x10 at T+1; r0_resp_valid at T+2, rdata=0, err=0.
- r1 reads 0x10 with the memory model returning 0xDEADBEEF -> mem_ren=1 at T+1; r1_resp_rdata=0xDEADBEEF at T+2.
- Both valid continuously for 4 transactions, FIXED_PRIO=0 -> grant order r0, r1, r0, r1. Repeat with FIXED_PRIO=1 -> r0, r0, r0, r0, and r1 never gets ready.
- r0 read at addr 0x13 -> mem_ren=mem_wen=0 in ACCESS; r0_resp_err=1, rdata=0.
- Hold r0_resp_ready=0 for 5 cycles while r1 is valid -> resp_valid and rdata stay stable, r1_req_ready=0 throughout. r1 is accepted in the cycle after the response handshake.
- Assert rst in the ACCESS cycle of a read -> next cycle all outputs are 0, state=IDLE, no resp_valid. The first tie afterwards is granted to r0.
